// File: rtl/cap_pkg.sv
// Shared types and sizes for the capture write-side controller.
package cap_pkg;

    localparam int ENTRIES = 512;
    localparam int AW      = 9;
    localparam int DW      = 4;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(ENTRIES);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT_TRIG,
        POST,
        DONE
    } state_t;

endpackage

// File: rtl/cap_decim.sv
// Sample decimator: emits cap_stb on one of every 2^decimator smpl_tick strobes.
module cap_decim
    import cap_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          smpl_tick,
    input  logic [DW-1:0] decimator,
    output logic          cap_stb
);

    logic [15:0] decim_cnt_q;
    logic [15:0] decim_cnt_d;
    logic [15:0] decim_max;

    assign decim_max = (16'd1 << decimator) - 16'd1;
    assign cap_stb   = smpl_tick && (decim_cnt_q == decim_max);

    always_comb begin
        decim_cnt_d = decim_cnt_q;
        if (clr) begin
            decim_cnt_d = '0;
        end else if (cap_stb) begin
            decim_cnt_d = '0;
        end else if (smpl_tick) begin
            decim_cnt_d = decim_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            decim_cnt_q <= '0;
        end else begin
            decim_cnt_q <= decim_cnt_d;
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// Capture write controller: fills a circular sample buffer around a trigger
// and reports the newest sample address for the downstream dump stage.
module capture_ctrl
    import cap_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          smpl_tick,
    input  logic [DW-1:0] decimator,
    input  logic          trig_in,
    input  logic [AW-1:0] trig_pos,
    input  logic          clr_done,
    output logic          cap_en,
    output logic          we,
    output logic [AW-1:0] cap_addr,
    output logic [AW-1:0] trace_end,
    output logic          armed,
    output logic          capture_done
);

    state_t        state_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW:0]   smpl_cnt_q;
    logic [AW-1:0] post_cnt_q;
    logic [AW-1:0] tp_q;
    logic          cap_en_q;
    logic          we_q;
    logic [AW-1:0] cap_addr_q;
    logic [AW-1:0] trace_end_q;
    logic          armed_q;
    logic          done_q;

    logic          cap_stb;
    logic          start_ok;
    logic          writing;

    assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
    assign writing  = cap_stb && ((state_q == PRE) || (state_q == WAIT_TRIG) || (state_q == POST));

    cap_decim u_decim (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_ok),
        .smpl_tick (smpl_tick),
        .decimator (decimator),
        .cap_stb   (cap_stb)
    );

    // The write port lags the strobe by one cycle; pointer and FSM advance together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            smpl_cnt_q  <= '0;
            post_cnt_q  <= '0;
            tp_q        <= '0;
            cap_en_q    <= 1'b0;
            we_q        <= 1'b0;
            cap_addr_q  <= '0;
            trace_end_q <= '0;
            armed_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cap_en_q <= 1'b0;
            we_q     <= 1'b0;
            if (writing) begin
                cap_en_q   <= 1'b1;
                we_q       <= 1'b1;
                cap_addr_q <= wr_ptr_q;
                wr_ptr_q   <= wr_ptr_q + AW'(1);
            end

            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        tp_q       <= trig_pos;
                        wr_ptr_q   <= '0;
                        smpl_cnt_q <= '0;
                        post_cnt_q <= '0;
                        done_q     <= 1'b0;
                        armed_q    <= 1'b0;
                        state_q    <= PRE;
                    end else if ((state_q == DONE) && clr_done) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                PRE: begin
                    if (cap_stb) begin
                        smpl_cnt_q <= smpl_cnt_q + (AW+1)'(1);
                        if ((smpl_cnt_q + (AW+1)'(1)) == (FULL_CNT - {1'b0, tp_q})) begin
                            armed_q <= 1'b1;
                            state_q <= WAIT_TRIG;
                        end
                    end
                end
                WAIT_TRIG: begin
                    // With no post-trigger room, a coincident strobe still counts as pre-trigger.
                    if (trig_in) begin
                        if (tp_q == '0) begin
                            trace_end_q <= cap_stb ? wr_ptr_q : (wr_ptr_q - AW'(1));
                            armed_q     <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= DONE;
                        end else if (cap_stb && (tp_q == AW'(1))) begin
                            trace_end_q <= wr_ptr_q;
                            armed_q     <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            if (cap_stb) begin
                                post_cnt_q <= AW'(1);
                            end
                            state_q <= POST;
                        end
                    end
                end
                POST: begin
                    if (cap_stb) begin
                        if ((post_cnt_q + AW'(1)) == tp_q) begin
                            trace_end_q <= wr_ptr_q;
                            armed_q     <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            post_cnt_q <= post_cnt_q + AW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cap_en       = cap_en_q;
    assign we           = we_q;
    assign cap_addr     = cap_addr_q;
    assign trace_end    = trace_end_q;
    assign armed        = armed_q;
    assign capture_done = done_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: expected write addresses are queued up
// front and popped whenever the DUT issues a RAM write.
module tb_capture_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       smplTick;
    logic [3:0] decimator;
    logic       trigIn;
    logic [8:0] trigPos;
    logic       clrDone;
    logic       capEn;
    logic       we;
    logic [8:0] capAddr;
    logic [8:0] traceEnd;
    logic       armed;
    logic       captureDone;

    logic [8:0] expQ[$];
    logic [8:0] expAddr;
    int         vectors;
    int         miscompares;
    int         wrCount;

    capture_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .smpl_tick    (smplTick),
        .decimator    (decimator),
        .trig_in      (trigIn),
        .trig_pos     (trigPos),
        .clr_done     (clrDone),
        .cap_en       (capEn),
        .we           (we),
        .cap_addr     (capAddr),
        .trace_end    (traceEnd),
        .armed        (armed),
        .capture_done (captureDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge, sample 1ns later and retire any write against the scoreboard.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (we || capEn) begin
            wrCount++;
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_write addr=%0d we=%0b cap_en=%0b required no write", capAddr, we, capEn);
            end else begin
                expAddr = expQ.pop_front();
                if (capAddr !== expAddr || we !== 1'b1 || capEn !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL write_addr got=%0d we=%0b cap_en=%0b required=%0d we=1 cap_en=1", capAddr, we, capEn, expAddr);
                end
            end
        end
    endtask

    task automatic pushRange(input int count);
        for (int i = 0; i < count; i++) expQ.push_back(9'(i % 512));
    endtask

    task automatic checkBit(input string name, input logic got, input logic req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("[TB] FAIL %s got=%0b required=%0b", name, got, req);
        end
    endtask

    task automatic checkVal(input string name, input int got, input int req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("[TB] FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        start = 1'b0; smplTick = 1'b0; trigIn = 1'b0; clrDone = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        expQ.delete();
        wrCount = 0;
    endtask

    task automatic startCapture(input logic [3:0] dec, input logic [8:0] tp);
        decimator = dec;
        trigPos   = tp;
        start     = 1'b1;
        cycle();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0; smplTick = 1'b0; trigIn = 1'b0; clrDone = 1'b0;
        decimator = '0; trigPos = '0;
        #1;
        checkBit("reset_cap_en", capEn, 1'b0);
        checkBit("reset_we", we, 1'b0);
        checkVal("reset_cap_addr", capAddr, 0);
        checkVal("reset_trace_end", traceEnd, 0);
        checkBit("reset_armed", armed, 1'b0);
        checkBit("reset_capture_done", captureDone, 1'b0);
        doReset();
    endtask

    task automatic test_full_capture();
        int postWrites;
        doReset();
        postWrites = 0;
        pushRange(655);
        smplTick = 1'b1;
        startCapture(4'd0, 9'd256);
        for (int s = 2; s <= 700; s++) begin
            cycle();
            if (s == 256) checkBit("armed_before_fill", armed, 1'b0);
            if (s == 257) begin
                checkBit("armed_after_fill", armed, 1'b1);
                checkVal("armed_addr", capAddr, 255);
            end
            if (s >= 401 && (we === 1'b1)) postWrites++;
            if (s == 655) checkBit("done_early", captureDone, 1'b0);
            if (s == 656) begin
                checkBit("done_full", captureDone, 1'b1);
                checkVal("trace_end_full", traceEnd, 142);
                checkBit("armed_cleared_full", armed, 1'b0);
            end
            trigIn = (s == 400);
        end
        checkVal("post_writes_full", postWrites, 256);
        checkVal("total_writes_full", wrCount, 655);
        checkVal("queue_left_full", expQ.size(), 0);
    endtask

    task automatic test_decimation();
        logic expWe;
        doReset();
        pushRange(14);
        smplTick = 1'b1;
        startCapture(4'd2, 9'd500);
        for (int s = 2; s <= 60; s++) begin
            cycle();
            expWe = (s >= 5) && (((s - 5) % 4) == 0);
            if (we !== expWe) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL decim_we step=%0d got=%0b required=%0b", s, we, expWe);
            end
            if (s >= 5) begin
                vectors++;
                if (int'(capAddr) !== (s - 5) / 4) begin
                    miscompares++;
                    $display("[TB] FAIL decim_addr step=%0d got=%0d required=%0d", s, capAddr, (s - 5) / 4);
                end
            end
            if (s == 49) checkBit("decim_armed", armed, 1'b1);
        end
        checkVal("queue_left_decim", expQ.size(), 0);
    endtask

    task automatic test_trig_in_pre();
        doReset();
        pushRange(519);
        smplTick = 1'b1;
        startCapture(4'd0, 9'd500);
        trigPos = 9'd3;
        for (int s = 2; s <= 540; s++) begin
            cycle();
            if (s == 12) begin
                checkBit("pre_trig_ignored_armed", armed, 1'b0);
                checkBit("pre_trig_ignored_done", captureDone, 1'b0);
            end
            if (s == 13) checkBit("pre_armed", armed, 1'b1);
            if (s == 519) checkBit("pre_done_early", captureDone, 1'b0);
            if (s == 520) begin
                checkBit("pre_done", captureDone, 1'b1);
                checkVal("pre_trace_end", traceEnd, 6);
            end
            trigIn = (s == 5) || (s == 20);
        end
        checkVal("pre_total_writes", wrCount, 519);
        checkVal("queue_left_pre", expQ.size(), 0);
    endtask

    task automatic test_tp_zero();
        doReset();
        pushRange(549);
        smplTick = 1'b1;
        startCapture(4'd0, 9'd0);
        for (int s = 2; s <= 560; s++) begin
            cycle();
            if (s == 512) checkBit("tp0_armed_early", armed, 1'b0);
            if (s == 513) checkBit("tp0_armed", armed, 1'b1);
            if (s == 550) begin
                checkVal("tp0_last_addr", capAddr, 36);
                checkBit("tp0_done_early", captureDone, 1'b0);
            end
            if (s == 551) begin
                checkBit("tp0_done", captureDone, 1'b1);
                checkVal("tp0_trace_end", traceEnd, 36);
                checkBit("tp0_armed_cleared", armed, 1'b0);
            end
            trigIn   = (s == 550);
            smplTick = (s < 550) || (s >= 552);
        end
        checkVal("tp0_total_writes", wrCount, 549);
        checkVal("queue_left_tp0", expQ.size(), 0);
    endtask

    task automatic test_back_to_back();
        wrCount  = 0;
        smplTick = 1'b0;
        clrDone  = 1'b1;
        startCapture(4'd0, 9'd300);
        clrDone = 1'b0;
        checkBit("restart_done_cleared", captureDone, 1'b0);
        checkVal("restart_trace_end_kept", traceEnd, 36);
        pushRange(10);
        smplTick = 1'b1;
        for (int s = 2; s <= 15; s++) begin
            cycle();
            if (s == 11) smplTick = 1'b0;
        end
        checkVal("restart_writes", wrCount, 10);
        checkVal("restart_trace_end_hold", traceEnd, 36);
        checkBit("restart_not_done", captureDone, 1'b0);
        checkVal("queue_left_restart", expQ.size(), 0);
    endtask

    task automatic test_reset_mid_post();
        doReset();
        pushRange(29);
        smplTick = 1'b1;
        startCapture(4'd0, 9'd500);
        for (int s = 2; s <= 30; s++) begin
            cycle();
            trigIn = (s == 20);
        end
        checkBit("post_armed_before_reset", armed, 1'b1);
        checkBit("post_we_before_reset", we, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        checkBit("async_cap_en", capEn, 1'b0);
        checkBit("async_we", we, 1'b0);
        checkVal("async_cap_addr", capAddr, 0);
        checkVal("async_trace_end", traceEnd, 0);
        checkBit("async_armed", armed, 1'b0);
        checkBit("async_capture_done", captureDone, 1'b0);
        checkVal("queue_left_async", expQ.size(), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        wrCount = 0;
        for (int s = 0; s < 10; s++) begin
            cycle();
        end
        checkVal("idle_writes_after_reset", wrCount, 0);
        expQ.push_back(9'd0);
        startCapture(4'd0, 9'd500);
        cycle();
        checkVal("restart_first_addr", capAddr, 0);
        checkVal("queue_left_after_restart", expQ.size(), 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        wrCount     = 0;
        test_reset();
        test_full_capture();
        test_decimation();
        test_trig_in_pre();
        test_tp_zero();
        test_back_to_back();
        test_reset_mid_post();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
